// File: rtl/gesture_pkg.sv
// gesture_pkg: zone encoding, counter sizing and threshold helpers shared by the joystick front end.
package gesture_pkg;

    typedef enum logic [1:0] {
        ZONE_CENTER = 2'd0,
        ZONE_LOW    = 2'd1,
        ZONE_HIGH   = 2'd2
    } zone_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int mid_of(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int hi_in_thr(input int w, input int off);
        return mid_of(w) + off;
    endfunction

    function automatic int hi_out_thr(input int w, input int off, input int hyst);
        return mid_of(w) + off - hyst;
    endfunction

    function automatic int lo_in_thr(input int w, input int off);
        return mid_of(w) - off;
    endfunction

    function automatic int lo_out_thr(input int w, input int off, input int hyst);
        return mid_of(w) - off + hyst;
    endfunction

    // The registration edge counts as the first sighting, so the
    // evaluations that follow it need only STABLE_CYCLES-1 more.
    function automatic int commit_need(input int stable);
        return (stable > 1) ? stable - 1 : 1;
    endfunction

endpackage

// File: rtl/axis_zone_fsm.sv
// axis_zone_fsm: one axis of the joystick front end -- hysteresis zone
// candidate, stability commit, level/pulse generation and auto-repeat.
module axis_zone_fsm
    import gesture_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int OFFSET        = 450,
    parameter int HYST          = 32,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pos_i,
    output logic             lo_o,
    output logic             hi_o,
    output logic             lo_pulse_o,
    output logic             hi_pulse_o
);
    localparam logic [WIDTH:0] HI_IN  = (WIDTH+1)'(hi_in_thr(WIDTH, OFFSET));
    localparam logic [WIDTH:0] HI_OUT = (WIDTH+1)'(hi_out_thr(WIDTH, OFFSET, HYST));
    localparam logic [WIDTH:0] LO_IN  = (WIDTH+1)'(lo_in_thr(WIDTH, OFFSET));
    localparam logic [WIDTH:0] LO_OUT = (WIDTH+1)'(lo_out_thr(WIDTH, OFFSET, HYST));
    localparam int CW = clog2_min1(STABLE_CYCLES + 1);
    localparam int RW = clog2_min1(REPEAT_CYCLES + 1);
    localparam logic [CW:0] NEED = (CW+1)'(commit_need(STABLE_CYCLES));
    localparam logic [RW-1:0] RLAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    zone_t zone_q, zone_d, prev_q, cand;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [WIDTH:0] p;
    logic [CW:0] run;
    logic commit, fire;
    logic lo_pulse_q, lo_pulse_d, hi_pulse_q, hi_pulse_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            zone_q     <= ZONE_CENTER;
            prev_q     <= ZONE_CENTER;
            cnt_q      <= '0;
            rep_q      <= '0;
            lo_pulse_q <= 1'b0;
            hi_pulse_q <= 1'b0;
        end else begin
            zone_q     <= zone_d;
            prev_q     <= cand;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            lo_pulse_q <= lo_pulse_d;
            hi_pulse_q <= hi_pulse_d;
        end
    end

    // Leaving a zone needs HYST extra travel back toward MID.
    always_comb begin
        p = {1'b0, pos_i};
        cand = (p > HI_IN || (zone_q == ZONE_HIGH && p > HI_OUT)) ? ZONE_HIGH :
               (p < LO_IN || (zone_q == ZONE_LOW && p < LO_OUT)) ? ZONE_LOW : ZONE_CENTER;
        run = (cand == prev_q) ? {1'b0, cnt_q} + (CW+1)'(2) : (CW+1)'(1);
        commit = cand != zone_q && run >= NEED;
        zone_d = commit ? cand : zone_q;
        cnt_d = (cand == zone_q || cand != prev_q || commit) ? '0 : cnt_q + CW'(1);
        rep_d = '0;
        fire = 1'b0;
        if (REPEAT_CYCLES > 0 && !commit && zone_q != ZONE_CENTER) begin
            fire = rep_q == RLAST;
            rep_d = fire ? '0 : rep_q + RW'(1);
        end
        lo_pulse_d = (commit && cand == ZONE_LOW) || (fire && zone_q == ZONE_LOW);
        hi_pulse_d = (commit && cand == ZONE_HIGH) || (fire && zone_q == ZONE_HIGH);
    end

    assign lo_o       = zone_q == ZONE_LOW;
    assign hi_o       = zone_q == ZONE_HIGH;
    assign lo_pulse_o = lo_pulse_q;
    assign hi_pulse_o = hi_pulse_q;

endmodule

// File: rtl/axis_gesture_debouncer.sv
// axis_gesture_debouncer: joystick front end turning raw X/Y positions and the
// start button into debounced direction levels and one-cycle gesture strobes.
module axis_gesture_debouncer
    import gesture_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int OFFSET        = 450,
    parameter int HYST          = 32,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic             fast_hz,
    input  logic             rst,
    input  logic [WIDTH-1:0] xPos,
    input  logic [WIDTH-1:0] yPos,
    input  logic             btnStart,
    output logic             btnL,
    output logic             btnR,
    output logic             btnD,
    output logic             btnU,
    output logic             pulseL,
    output logic             pulseR,
    output logic             pulseD,
    output logic             pulseU,
    output logic             btnStartDb,
    output logic             startPulse
);
    localparam logic [WIDTH-1:0] MID = WIDTH'(mid_of(WIDTH));
    localparam int CW = clog2_min1(STABLE_CYCLES + 1);
    localparam logic [CW:0] NEED = (CW+1)'(commit_need(STABLE_CYCLES));

    if (HYST >= OFFSET || OFFSET >= mid_of(WIDTH) || STABLE_CYCLES < 1) begin : g_bad_params
        $error("axis_gesture_debouncer: need HYST < OFFSET < MID and STABLE_CYCLES >= 1");
    end

    logic [WIDTH-1:0] x_q, y_q;
    logic btn_q, sdb_q, sdb_d, sprev_q, spulse_q, spulse_d, s_commit;
    logic [CW-1:0] scnt_q, scnt_d;
    logic [CW:0] s_run;

    always_ff @(posedge fast_hz) begin
        if (rst) begin
            x_q      <= MID;
            y_q      <= MID;
            btn_q    <= 1'b0;
            sdb_q    <= 1'b0;
            sprev_q  <= 1'b0;
            scnt_q   <= '0;
            spulse_q <= 1'b0;
        end else begin
            x_q      <= xPos;
            y_q      <= yPos;
            btn_q    <= btnStart;
            sdb_q    <= sdb_d;
            sprev_q  <= btn_q;
            scnt_q   <= scnt_d;
            spulse_q <= spulse_d;
        end
    end

    // Start button: same stability rule as an axis, with only two zones.
    always_comb begin
        s_run = (btn_q == sprev_q) ? {1'b0, scnt_q} + (CW+1)'(2) : (CW+1)'(1);
        s_commit = btn_q != sdb_q && s_run >= NEED;
        scnt_d = (btn_q == sdb_q || btn_q != sprev_q || s_commit) ? '0 : scnt_q + CW'(1);
        sdb_d = s_commit ? btn_q : sdb_q;
        spulse_d = s_commit && btn_q;
    end

    axis_zone_fsm #(
        .WIDTH(WIDTH), .OFFSET(OFFSET), .HYST(HYST),
        .STABLE_CYCLES(STABLE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_x (
        .clk_i(fast_hz), .rst_i(rst), .pos_i(x_q),
        .lo_o(btnL), .hi_o(btnR), .lo_pulse_o(pulseL), .hi_pulse_o(pulseR)
    );

    axis_zone_fsm #(
        .WIDTH(WIDTH), .OFFSET(OFFSET), .HYST(HYST),
        .STABLE_CYCLES(STABLE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_y (
        .clk_i(fast_hz), .rst_i(rst), .pos_i(y_q),
        .lo_o(btnD), .hi_o(btnU), .lo_pulse_o(pulseD), .hi_pulse_o(pulseU)
    );

    assign btnStartDb = sdb_q;
    assign startPulse = spulse_q;

endmodule

// File: tb/tb_axis_gesture_debouncer.sv
// tb_axis_gesture_debouncer: directed scenarios plus random stimulus on two
// instances (no repeat / repeat every 8), compared every cycle to a reference model.
module tb_axis_gesture_debouncer;
    localparam int W = 10, S = 4, R1 = 8, MID = 512;
    localparam int HI_IN = 962, HI_OUT = 930, LO_IN = 62, LO_OUT = 94;

    logic fast_hz = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] xPos = W'(MID), yPos = W'(MID);
    logic btnStart = 1'b0;
    logic bl[2], br[2], bd[2], bu[2], pl[2], pr[2], pd[2], pu[2], sdb[2], spl[2];

    int checks = 0, fails = 0;
    int mz[2][2], mrun[2][2], mlast[2][2], mrep[2][2], mp[2][2];
    int rx, ry, rb, sc, srun, slast, sp;
    int vals[18] = '{0, 10, 61, 62, 63, 93, 94, 95, 400, 512, 929, 930, 931, 961, 962, 963, 1000, 1023};

    always #5 fast_hz = ~fast_hz;

    axis_gesture_debouncer #(.WIDTH(W), .OFFSET(450), .HYST(32), .STABLE_CYCLES(S), .REPEAT_CYCLES(0)) dut0 (
        .fast_hz(fast_hz), .rst(rst), .xPos(xPos), .yPos(yPos), .btnStart(btnStart),
        .btnL(bl[0]), .btnR(br[0]), .btnD(bd[0]), .btnU(bu[0]),
        .pulseL(pl[0]), .pulseR(pr[0]), .pulseD(pd[0]), .pulseU(pu[0]),
        .btnStartDb(sdb[0]), .startPulse(spl[0])
    );

    axis_gesture_debouncer #(.WIDTH(W), .OFFSET(450), .HYST(32), .STABLE_CYCLES(S), .REPEAT_CYCLES(R1)) dut1 (
        .fast_hz(fast_hz), .rst(rst), .xPos(xPos), .yPos(yPos), .btnStart(btnStart),
        .btnL(bl[1]), .btnR(br[1]), .btnD(bd[1]), .btnU(bu[1]),
        .pulseL(pl[1]), .pulseR(pr[1]), .pulseD(pd[1]), .pulseU(pu[1]),
        .btnStartDb(sdb[1]), .startPulse(spl[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Zones: 0 centre, 1 low, 2 high. mp holds the zone whose pulse fires this cycle.
    task automatic axis_step(input int d, input int a, input int p, input int rep);
        int c;
        c = (p > HI_IN || (mz[d][a] == 2 && p > HI_OUT)) ? 2 :
            (p < LO_IN || (mz[d][a] == 1 && p < LO_OUT)) ? 1 : 0;
        mp[d][a] = 0;
        if (c == mz[d][a]) mrun[d][a] = 0;
        else mrun[d][a] = (c == mlast[d][a]) ? mrun[d][a] + 1 : 1;
        mlast[d][a] = c;
        if (c != mz[d][a] && mrun[d][a] >= S - 1) begin
            mz[d][a] = c;
            mrun[d][a] = 0;
            mrep[d][a] = 0;
            mp[d][a] = c;
        end else if (rep > 0 && mz[d][a] != 0) begin
            mrep[d][a]++;
            if (mrep[d][a] == rep) begin
                mp[d][a] = mz[d][a];
                mrep[d][a] = 0;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 2; a++) begin
                    mz[d][a] = 0; mrun[d][a] = 0; mlast[d][a] = 0; mrep[d][a] = 0; mp[d][a] = 0;
                end
            sc = 0; srun = 0; slast = 0; sp = 0;
            rx = MID; ry = MID; rb = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                axis_step(d, 0, rx, d == 1 ? R1 : 0);
                axis_step(d, 1, ry, d == 1 ? R1 : 0);
            end
            sp = 0;
            if (rb == sc) srun = 0;
            else srun = (rb == slast) ? srun + 1 : 1;
            slast = rb;
            if (rb != sc && srun >= S - 1) begin
                sc = rb;
                srun = 0;
                sp = rb;
            end
            rx = int'(xPos); ry = int'(yPos); rb = int'(btnStart);
        end
    endtask

    function automatic logic [9:0] expect_vec(input int d);
        return {mz[d][0] == 1, mz[d][0] == 2, mz[d][1] == 1, mz[d][1] == 2,
                mp[d][0] == 1, mp[d][0] == 2, mp[d][1] == 1, mp[d][1] == 2, sc == 1, sp == 1};
    endfunction

    task automatic tick();
        @(posedge fast_hz);
        model_step();
        @(negedge fast_hz);
        check("dut0_outputs", 32'({bl[0], br[0], bd[0], bu[0], pl[0], pr[0], pd[0], pu[0], sdb[0], spl[0]}),
              32'(expect_vec(0)));
        check("dut1_outputs", 32'({bl[1], br[1], bd[1], bu[1], pl[1], pr[1], pd[1], pu[1], sdb[1], spl[1]}),
              32'(expect_vec(1)));
    endtask

    task automatic hold(input int x, input int y, input int b, input int n);
        xPos = W'(x); yPos = W'(y); btnStart = b[0];
        repeat (n) tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        hold(1000, MID, 0, 3);
        rst = 1'b0;
        hold(1000, MID, 0, 10);
        hold(MID, MID, 0, 8);
        hold(963, MID, 0, 3);
        hold(MID, MID, 0, 6);
        hold(962, MID, 0, 20);
        hold(1000, MID, 0, 8);
        hold(940, MID, 0, 20);
        hold(930, MID, 0, 8);
        hold(10, MID, 0, 8);
        hold(1000, MID, 0, 8);
        hold(MID, MID, 0, 8);
        hold(MID, 1023, 0, 40);
        hold(MID, MID, 0, 8);
        foreach (vals[i]) if (i < 5) hold(MID, MID, (i == 0 || i == 2 || i == 3) ? 1 : 0, 1);
        hold(MID, MID, 1, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold(MID, MID, 1, 8);
        hold(MID, MID, 0, 8);
        for (int k = 0; k < 600; k++) begin
            n = int'($urandom_range(1, 7));
            rst = ($urandom_range(0, 99) < 2);
            hold($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) : vals[$urandom_range(0, 17)],
                 $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) : vals[$urandom_range(0, 17)],
                 int'($urandom_range(0, 1)), rst ? 1 : n);
            rst = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
